// File: rtl/pll_seq_pkg.sv
// Shared types and widths for the PLL lock sequencer.
package pll_seq_pkg;

  localparam int unsigned CNT_W    = 24;
  localparam int unsigned RELOCK_W = 8;

  typedef enum logic [2:0] {
    StWaitLock = 3'd0,
    StHold     = 3'd1,
    StRelA     = 3'd2,
    StRelB     = 3'd3,
    StRun      = 3'd4,
    StFault    = 3'd5
  } seq_state_e;

endpackage

// File: rtl/lock_sync.sv
// Two-flop synchronizer for a PLL locked flag; clears to 0 on reset.
module lock_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Qualifies both PLL locks, releases the carrier then baseband resets, then enables TX.
// Optional LED heartbeat in RUN when PLL_SEQ_HEARTBEAT_EN is defined.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned LOCK_HOLD = 16000,
  parameter int unsigned RST_GAP   = 16,
  parameter int unsigned TIMEOUT   = 16000000,
  parameter int unsigned HB_DIV    = 8000000
) (
  input  logic                hwclk,
  input  logic                rst,
  input  logic                lock_a,
  input  logic                lock_b,
  input  logic                fault_clr,
  output logic                rst_a_out,
  output logic                rst_b_out,
  output logic                tx_en,
  output logic                fault,
  output logic [2:0]          state_o,
  output logic [RELOCK_W-1:0] relock_cnt,
  output logic                heartbeat
);

  localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(LOCK_HOLD - 1);
  localparam logic [CNT_W-1:0] GapLast     = CNT_W'(RST_GAP - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

  logic             w_lock_a;
  logic             w_lock_b;
  logic             w_both;
  logic             w_loss;
  seq_state_e       r_state;
  seq_state_e       w_state_d;
  logic [CNT_W-1:0] r_cnt;

  logic w_rst_a_d;
  logic w_rst_b_d;
  logic w_tx_en_d;
  logic w_fault_d;
  logic r_rst_a;
  logic r_rst_b;
  logic r_tx_en;
  logic r_fault;
  logic [RELOCK_W-1:0] r_relock;

  lock_sync u_sync_a (
    .i_clk (hwclk),
    .i_rst (rst),
    .i_d   (lock_a),
    .o_q   (w_lock_a)
  );

  lock_sync u_sync_b (
    .i_clk (hwclk),
    .i_rst (rst),
    .i_d   (lock_b),
    .o_q   (w_lock_b)
  );

  assign w_both = w_lock_a & w_lock_b;

  always_ff @(posedge hwclk) begin
    if (rst) begin
      r_state <= StWaitLock;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= (w_state_d != r_state) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Lock loss is tested before any counter expiry so it always wins.
  always_comb begin
    w_state_d = r_state;
    w_loss    = 1'b0;
    case (r_state)
      StWaitLock: begin
        if (w_both)                    w_state_d = StHold;
        else if (r_cnt == TimeoutLast) w_state_d = StFault;
      end
      StHold: begin
        if (!w_both)                w_state_d = StWaitLock;
        else if (r_cnt == HoldLast) w_state_d = StRelA;
      end
      StRelA: begin
        if (!w_both) begin
          w_state_d = StWaitLock;
          w_loss    = 1'b1;
        end else if (r_cnt == GapLast) begin
          w_state_d = StRelB;
        end
      end
      StRelB: begin
        if (!w_both) begin
          w_state_d = StWaitLock;
          w_loss    = 1'b1;
        end else if (r_cnt == GapLast) begin
          w_state_d = StRun;
        end
      end
      StRun: begin
        if (!w_both) begin
          w_state_d = StWaitLock;
          w_loss    = 1'b1;
        end
      end
      StFault: begin
        if (fault_clr) w_state_d = StWaitLock;
      end
      default: w_state_d = StWaitLock;
    endcase
  end

  always_comb begin
    w_rst_a_d = 1'b1;
    w_rst_b_d = 1'b1;
    w_tx_en_d = 1'b0;
    w_fault_d = 1'b0;
    case (w_state_d)
      StRelA: w_rst_a_d = 1'b0;
      StRelB: begin
        w_rst_a_d = 1'b0;
        w_rst_b_d = 1'b0;
      end
      StRun: begin
        w_rst_a_d = 1'b0;
        w_rst_b_d = 1'b0;
        w_tx_en_d = 1'b1;
      end
      StFault: w_fault_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      r_rst_a  <= 1'b1;
      r_rst_b  <= 1'b1;
      r_tx_en  <= 1'b0;
      r_fault  <= 1'b0;
      r_relock <= '0;
    end else begin
      r_rst_a <= w_rst_a_d;
      r_rst_b <= w_rst_b_d;
      r_tx_en <= w_tx_en_d;
      r_fault <= w_fault_d;
      if (w_loss && (r_relock != '1)) r_relock <= r_relock + RELOCK_W'(1);
    end
  end

  assign rst_a_out  = r_rst_a;
  assign rst_b_out  = r_rst_b;
  assign tx_en      = r_tx_en;
  assign fault      = r_fault;
  assign state_o    = r_state;
  assign relock_cnt = r_relock;

`ifdef PLL_SEQ_HEARTBEAT_EN
  localparam logic [CNT_W-1:0] HbLast = CNT_W'(HB_DIV - 1);

  logic [CNT_W-1:0] r_hb_div;
  logic             r_heartbeat;

  // Divider restarts on every RUN entry so the first toggle is a full HB_DIV in.
  always_ff @(posedge hwclk) begin
    if (rst || (w_state_d != StRun) || (r_state != StRun)) begin
      r_hb_div    <= '0;
      r_heartbeat <= 1'b0;
    end else if (r_hb_div == HbLast) begin
      r_hb_div    <= '0;
      r_heartbeat <= ~r_heartbeat;
    end else begin
      r_hb_div <= r_hb_div + CNT_W'(1);
    end
  end

  assign heartbeat = r_heartbeat;
`else
  // HB_DIV has no effect without the heartbeat divider.
  assign heartbeat = (HB_DIV == 0) & 1'b0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with LOCK_HOLD=4, RST_GAP=3, TIMEOUT=20, HB_DIV=2.
module tb_pll_lock_sequencer;

  localparam logic [2:0] SWait  = 3'd0;
  localparam logic [2:0] SHold  = 3'd1;
  localparam logic [2:0] SRelA  = 3'd2;
  localparam logic [2:0] SRelB  = 3'd3;
  localparam logic [2:0] SRun   = 3'd4;
  localparam logic [2:0] SFault = 3'd5;
`ifdef PLL_SEQ_HEARTBEAT_EN
  localparam logic HbOn = 1'b1;
`else
  localparam logic HbOn = 1'b0;
`endif

  logic       hwclk = 1'b0;
  logic       rst;
  logic       lock_a;
  logic       lock_b;
  logic       fault_clr;
  logic       rst_a_out;
  logic       rst_b_out;
  logic       tx_en;
  logic       fault;
  logic [2:0] state_o;
  logic [7:0] relock_cnt;
  logic       heartbeat;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  pll_lock_sequencer #(
    .LOCK_HOLD (4),
    .RST_GAP   (3),
    .TIMEOUT   (20),
    .HB_DIV    (2)
  ) dut (
    .hwclk      (hwclk),
    .rst        (rst),
    .lock_a     (lock_a),
    .lock_b     (lock_b),
    .fault_clr  (fault_clr),
    .rst_a_out  (rst_a_out),
    .rst_b_out  (rst_b_out),
    .tx_en      (tx_en),
    .fault      (fault),
    .state_o    (state_o),
    .relock_cnt (relock_cnt),
    .heartbeat  (heartbeat)
  );

  always #5 hwclk = ~hwclk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge hwclk);
    #1;
    cyc++;
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge hwclk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    int k = 0;
    while (state_o !== st && k < budget) begin
      tick();
      k++;
    end
    check_eq(tag, {29'd0, state_o}, {29'd0, st});
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_rst_a"}, rst_a_out, 1);
    check_eq({tag, "_rst_b"}, rst_b_out, 1);
    check_eq({tag, "_tx_en"}, tx_en, 0);
    check_eq({tag, "_fault"}, fault, 0);
    check_eq({tag, "_state"}, state_o, SWait);
    check_eq({tag, "_relock"}, relock_cnt, 0);
    check_eq({tag, "_hb"}, heartbeat, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    lock_a    = 1'b0;
    lock_b    = 1'b0;
    fault_clr = 1'b0;

    // Clean start
    do_reset();
    check_reset_values("por");
    wait_to(5);
    lock_a = 1'b1;
    lock_b = 1'b1;
    wait_to(7);  check_eq("cs_state7", state_o, SWait);
    wait_to(8);  check_eq("cs_state8", state_o, SHold);
    wait_to(11); check_eq("cs_rst_a11", rst_a_out, 1);
    wait_to(12); check_eq("cs_rst_a12", rst_a_out, 0);
                 check_eq("cs_state12", state_o, SRelA);
                 check_eq("cs_rst_b12", rst_b_out, 1);
    wait_to(14); check_eq("cs_rst_b14", rst_b_out, 1);
    wait_to(15); check_eq("cs_rst_b15", rst_b_out, 0);
                 check_eq("cs_state15", state_o, SRelB);
    wait_to(17); check_eq("cs_tx17", tx_en, 0);
    wait_to(18); check_eq("cs_tx18", tx_en, 1);
                 check_eq("cs_state18", state_o, SRun);
                 check_eq("cs_hb18", heartbeat, 0);
    wait_to(19); check_eq("cs_hb19", heartbeat, 0);
    wait_to(20); check_eq("cs_hb20", heartbeat, HbOn);
    wait_to(21); check_eq("cs_hb21", heartbeat, HbOn);
    wait_to(22); check_eq("cs_hb22", heartbeat, 0);

    // Loss in RUN
    wait_to(25);
    lock_a = 1'b0;
    wait_to(27); check_eq("loss_tx27", tx_en, 1);
    wait_to(28); check_eq("loss_tx28", tx_en, 0);
                 check_eq("loss_rst_a28", rst_a_out, 1);
                 check_eq("loss_rst_b28", rst_b_out, 1);
                 check_eq("loss_state28", state_o, SWait);
                 check_eq("loss_relock28", relock_cnt, 1);
                 check_eq("loss_hb28", heartbeat, 0);
    wait_to(30);
    lock_a = 1'b1;
    wait_to(32); check_eq("rl_state32", state_o, SWait);
    wait_to(33); check_eq("rl_state33", state_o, SHold);
    wait_to(42); check_eq("rl_tx42", tx_en, 0);
    wait_to(43); check_eq("rl_tx43", tx_en, 1);
                 check_eq("rl_state43", state_o, SRun);

    // Repeated one-cycle drops of lock_a in RUN up to 300 losses
    for (int i = 2; i <= 300; i++) begin
      wait_state("sat_run", SRun, 40);
      lock_a = 1'b0;
      tick();
      lock_a = 1'b1;
      tick();
      tick();
      tick();
      if (i == 100) check_eq("sat_relock100", relock_cnt, 100);
      if (i == 255) check_eq("sat_relock255", relock_cnt, 255);
      if (i == 256) check_eq("sat_relock256", relock_cnt, 255);
    end
    check_eq("sat_relock300", relock_cnt, 255);

    // Reset mid-REL_B
    wait_state("mid_relb", SRelB, 40);
    tick();
    do_reset();
    check_reset_values("mid");
    wait_to(2); check_eq("mid_state2", state_o, SWait);
    wait_to(3); check_eq("mid_state3", state_o, SHold);
    wait_to(7); check_eq("mid_state7", state_o, SRelA);

    // Lock glitch in HOLD, coinciding with HOLD expiry
    lock_a = 1'b0;
    lock_b = 1'b0;
    do_reset();
    wait_to(5);
    lock_a = 1'b1;
    lock_b = 1'b1;
    wait_to(8);  check_eq("gl_state8", state_o, SHold);
    wait_to(9);
    lock_b = 1'b0;
    wait_to(10);
    lock_b = 1'b1;
    wait_to(12); check_eq("gl_state12", state_o, SWait);
                 check_eq("gl_rst_a12", rst_a_out, 1);
    wait_to(13); check_eq("gl_state13", state_o, SHold);
    wait_to(16); check_eq("gl_state16", state_o, SHold);
                 check_eq("gl_rst_a16", rst_a_out, 1);
    wait_to(17); check_eq("gl_state17", state_o, SRelA);
                 check_eq("gl_rst_a17", rst_a_out, 0);
                 check_eq("gl_relock17", relock_cnt, 0);

    // Timeout into FAULT and recovery
    lock_a = 1'b0;
    lock_b = 1'b0;
    do_reset();
    wait_to(19); check_eq("to_state19", state_o, SWait);
                 check_eq("to_fault19", fault, 0);
    wait_to(20); check_eq("to_state20", state_o, SFault);
                 check_eq("to_fault20", fault, 1);
                 check_eq("to_rst_a20", rst_a_out, 1);
                 check_eq("to_tx20", tx_en, 0);
    wait_to(21);
    lock_a = 1'b1;
    lock_b = 1'b1;
    wait_to(26); check_eq("to_state26", state_o, SFault);
    fault_clr = 1'b1;
    wait_to(27); check_eq("to_state27", state_o, SWait);
                 check_eq("to_fault27", fault, 0);
    fault_clr = 1'b0;
    wait_to(28); check_eq("to_state28", state_o, SHold);
    fault_clr = 1'b1;
    wait_to(29); check_eq("to_clr_ignored29", state_o, SHold);
    fault_clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
